// File: rtl/mac_accumulator.sv
// mac_accumulator
// Signed multiply-accumulate back end. Takes a stream of INT8xINT8 products
// from an upstream multiplier, adds them to a preloaded bias with saturation,
// and holds the result until downstream accepts it.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for start; accumulator keeps the last result
//   ACCUM | summing products, one per prod_valid, until cnt reaches its end
//   HOLD  | result presented on acc_out with acc_valid, waiting for acc_ready
//
module mac_accumulator #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic signed [ACC_W-1:0] bias,
  input  logic                    prod_valid,
  input  logic signed [15:0]      product,
  output logic                    busy,
  output logic                    acc_valid,
  output logic signed [ACC_W-1:0] acc_out,
  input  logic                    acc_ready,
  output logic                    ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [LEN_W-1:0]        CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]        CNT_ZERO = '0;

  state_t                    state_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [LEN_W-1:0]          cnt_q;
  logic                      ovf_q;
  logic                      busy_q;
  logic                      valid_q;

  logic signed [ACC_W:0]     sum_w;
  logic                      sat_hi;
  logic                      sat_lo;
  logic signed [ACC_W-1:0]   acc_d;
  logic                      ovf_d;
  logic                      last_prod;

  // Saturating adder: one guard bit catches overflow in either direction,
  // which shows up as the top two bits of the wide sum disagreeing.
  always_comb begin
    sum_w  = {acc_q[ACC_W-1], acc_q}
           + {{(ACC_W+1-16){product[15]}}, product};
    sat_hi = ~sum_w[ACC_W] &  sum_w[ACC_W-1];
    sat_lo =  sum_w[ACC_W] & ~sum_w[ACC_W-1];
    if (sat_hi) begin
      acc_d = ACC_MAX;
    end else if (sat_lo) begin
      acc_d = ACC_MIN;
    end else begin
      acc_d = sum_w[ACC_W-1:0];
    end
    ovf_d     = ovf_q | sat_hi | sat_lo;
    last_prod = (cnt_q == CNT_ONE);
  end

  // Sequencer with registered status outputs; reset drops any partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q  <= bias;
            cnt_q  <= len;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (len == CNT_ZERO) begin
              // Empty dot product: the bias itself is the result.
              state_q <= HOLD;
              valid_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
              valid_q <= 1'b0;
            end
          end
        end

        ACCUM: begin
          if (prod_valid) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_q - CNT_ONE;
            if (last_prod) begin
              state_q <= HOLD;
              valid_q <= 1'b1;
            end
          end
        end

        HOLD: begin
          // Start arriving alongside the handshake is dropped on purpose;
          // a new job only begins from a settled IDLE.
          if (acc_ready) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Outputs come straight from flops.
  always_comb begin
    busy      = busy_q;
    acc_valid = valid_q;
    acc_out   = acc_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed plus randomized bench for mac_accumulator. Expected results come
// from a plain-arithmetic model of a saturated running sum.
module tb_mac_accumulator;

  localparam int ACC_W = 32;
  localparam int LEN_W = 16;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic [LEN_W-1:0]        len;
  logic signed [ACC_W-1:0] bias;
  logic                    prod_valid;
  logic signed [15:0]      product;
  logic                    busy;
  logic                    acc_valid;
  logic signed [ACC_W-1:0] acc_out;
  logic                    acc_ready;
  logic                    ovf;

  int checks;
  int failures;

  mac_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .bias       (bias),
    .prod_valid (prod_valid),
    .product    (product),
    .busy       (busy),
    .acc_valid  (acc_valid),
    .acc_out    (acc_out),
    .acc_ready  (acc_ready),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set after return apply to the next edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: saturated running sum, ovf sticky once any step clamps.
  function automatic void ref_sum(input longint b, input longint prods[$],
                                  output longint res, output bit o);
    longint a;
    a = b;
    o = 1'b0;
    foreach (prods[i]) begin
      a = a + prods[i];
      if (a > MAXV) begin a = MAXV; o = 1'b1; end
      if (a < MINV) begin a = MINV; o = 1'b1; end
    end
    res = a;
  endfunction

  task automatic do_start(input int l, input longint b);
    start = 1'b1;
    len   = LEN_W'(l);
    bias  = ACC_W'(b);
    cyc();
    start = 1'b0;
  endtask

  task automatic feed(input longint p);
    prod_valid = 1'b1;
    product    = 16'(p);
    cyc();
    prod_valid = 1'b0;
  endtask

  task automatic handshake();
    acc_ready = 1'b1;
    cyc();
    acc_ready = 1'b0;
  endtask

  longint q[$];
  longint exp_res;
  bit     exp_ovf;
  logic signed [ACC_W-1:0] held;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; len = '0; bias = '0;
    prod_valid = 1'b0; product = '0; acc_ready = 1'b0;
    #12;
    chk("reset_acc", acc_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_valid", acc_valid, 0);
    chk("reset_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Basic four-product dot product
    q = '{3, -5, 127, -16384};
    ref_sum(10, q, exp_res, exp_ovf);
    do_start(4, 10);
    chk("basic_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      chk("basic_not_valid_yet", acc_valid, 0);
      feed(q[i]);
    end
    chk("basic_valid", acc_valid, 1);
    chk("basic_acc", acc_out, -16249);
    chk("basic_model", acc_out, exp_res);
    chk("basic_ovf", ovf, 0);
    handshake();
    chk("basic_valid_drop", acc_valid, 0);
    chk("basic_busy_drop", busy, 0);

    // prod_valid in IDLE is ignored
    feed(500);
    chk("idle_prod_ignored", acc_out, -16249);

    // Zero-length job
    do_start(0, -7);
    chk("len0_valid", acc_valid, 1);
    chk("len0_acc", acc_out, -7);
    chk("len0_busy", busy, 1);
    cyc(); cyc();
    chk("len0_busy_hold", busy, 1);
    handshake();
    chk("len0_busy_drop", busy, 0);

    // Positive saturation, then the next start clears ovf
    do_start(2, MAXV - 99);
    feed(16129);
    feed(16129);
    chk("sat_pos_acc", acc_out, MAXV);
    chk("sat_pos_ovf", ovf, 1);
    handshake();
    chk("sat_ovf_sticky_idle", ovf, 1);
    do_start(1, 0);
    chk("sat_ovf_cleared", ovf, 0);
    feed(1);
    handshake();

    // Negative saturation with recovery afterwards: ovf stays sticky
    q = '{-16384, 16000};
    ref_sum(MINV + 10, q, exp_res, exp_ovf);
    do_start(2, MINV + 10);
    feed(q[0]);
    chk("sat_neg_mid", acc_out, MINV);
    feed(q[1]);
    chk("sat_neg_acc", acc_out, exp_res);
    chk("sat_neg_ovf", ovf, exp_ovf);
    handshake();

    // Gapped products, start pulses while busy, long HOLD backpressure
    for (int t = 0; t < 3; t++) begin
      q = {};
      for (int i = 0; i < 3; i++) q.push_back($signed(16'($urandom_range(0, 65535))));
      ref_sum(t * 1000 - 1500, q, exp_res, exp_ovf);
      do_start(3, t * 1000 - 1500);
      for (int i = 0; i < 3; i++) begin
        int gap;
        gap = $urandom_range(0, 5);
        for (int g = 0; g < gap; g++) begin
          start = 1'b1; len = 16'd1; bias = 32'sd5;
          cyc();
          start = 1'b0;
        end
        feed(q[i]);
      end
      chk("gap_valid", acc_valid, 1);
      chk("gap_acc", acc_out, exp_res);
      held = acc_out;
      for (int k = 0; k < 10; k++) begin
        start = 1'b1; prod_valid = 1'b1; product = 16'sd77;
        cyc();
        chk("hold_stable_acc", acc_out, held);
        chk("hold_stable_valid", acc_valid, 1);
      end
      // start coinciding with the handshake is dropped
      acc_ready = 1'b1; start = 1'b1; prod_valid = 1'b0;
      cyc();
      acc_ready = 1'b0; start = 1'b0;
      chk("hs_start_ignored_busy", busy, 0);
      chk("hs_start_ignored_valid", acc_valid, 0);
      cyc();
      chk("hs_start_still_idle", busy, 0);
    end

    // Reset mid-ACCUM
    do_start(5, 100);
    feed(40);
    feed(50);
    rst = 1'b1;
    #1;
    chk("rst_mid_acc", acc_out, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", acc_valid, 0);
    cyc();
    chk("rst_no_valid_pulse", acc_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    do_start(1, 0);
    feed(9);
    chk("post_rst_acc", acc_out, 9);
    chk("post_rst_valid", acc_valid, 1);
    handshake();

    // Reset mid-HOLD
    do_start(0, 1234);
    rst = 1'b1;
    #1;
    chk("rst_hold_valid", acc_valid, 0);
    chk("rst_hold_acc", acc_out, 0);
    @(negedge clk);
    rst = 1'b0;

    // Max length does not terminate early via counter wrap
    do_start((1 << LEN_W) - 1, 0);
    for (int i = 0; i < 4; i++) feed(1);
    chk("maxlen_busy", busy, 1);
    chk("maxlen_no_valid", acc_valid, 0);
    chk("maxlen_acc", acc_out, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Randomized jobs against the model
    for (int t = 0; t < 40; t++) begin
      int l;
      longint b;
      l = $urandom_range(0, 6);
      case ($urandom_range(0, 3))
        0: b = longint'($urandom_range(0, 2000)) - 1000;
        1: b = MAXV - longint'($urandom_range(0, 40000));
        2: b = MINV + longint'($urandom_range(0, 40000));
        default: b = longint'($signed(32'($urandom())));
      endcase
      q = {};
      for (int i = 0; i < l; i++) q.push_back($signed(16'($urandom_range(0, 65535))));
      ref_sum(b, q, exp_res, exp_ovf);
      do_start(l, b);
      for (int i = 0; i < l; i++) begin
        int gap;
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) cyc();
        feed(q[i]);
      end
      chk("rnd_valid", acc_valid, 1);
      chk("rnd_acc", acc_out, exp_res);
      chk("rnd_ovf", ovf, exp_ovf);
      for (int d = 0; d < int'($urandom_range(0, 3)); d++) cyc();
      handshake();
      chk("rnd_released", busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameter ACC_W, default 32: accumulator and result width in bits, signed.
REQ-002 Parameter LEN_W, default 16: width of the product-count field.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: one-cycle request to begin a new dot product; honoured only in IDLE.
REQ-006 Port len, input, LEN_W: number of products to accumulate; sampled on an accepted start.
REQ-007 Port bias, input, ACC_W, signed: initial accumulator value; sampled on an accepted start.
REQ-008 Port prod_valid, input, 1: product qualifier, driven by the upstream multiplier's done.
REQ-009 Port product, input, 16, signed: INT8xINT8 product from the upstream multiplier.
REQ-010 Port busy, output, 1: high in ACCUM or HOLD.
REQ-011 Port acc_valid, output, 1: result available; high exactly in HOLD.
REQ-012 Port acc_out, output, ACC_W, signed: registered accumulated result.
REQ-013 Port acc_ready, input, 1: downstream accepts the result when it is high together with acc_valid.
REQ-014 Port ovf, output, 1: sticky saturation flag for the current dot product.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCUM and HOLD.
REQ-016 IDLE with start=1 and len!=0: the block SHALL load acc<=bias, cnt<=len and ovf<=0, then enter ACCUM.
REQ-017 IDLE with start=1 and len==0: the block SHALL load acc<=bias and ovf<=0, then enter HOLD directly, so acc_valid rises on the next cycle.
REQ-018 ACCUM with prod_valid=1: acc SHALL become sat(acc + sign-extended product), and cnt SHALL decrement by 1.
REQ-019 ACCUM with prod_valid=1 and cnt==1: the block SHALL enter HOLD. acc_valid rises the cycle after the last prod_valid, giving 1-cycle latency.
REQ-020 ACCUM with prod_valid=0: acc and cnt SHALL hold, with no timeout.
REQ-021 HOLD with acc_ready=1: the block SHALL return to IDLE, and acc_valid SHALL deassert on the next cycle.
REQ-022 HOLD with acc_ready=0: the block SHALL hold acc_out and ovf stable, for any number of cycles.
REQ-023 acc_out SHALL equal the internal accumulator register at all times, so it is directly registered.
REQ-024 The adder SHALL compute at ACC_W+1 bits. Results above 2^(ACC_W-1)-1 SHALL clamp to that maximum, and results below -2^(ACC_W-1) SHALL clamp to that minimum.
REQ-025 Any clamp SHALL set ovf=1. ovf SHALL stay set until the next accepted start or reset.
REQ-026 start SHALL be ignored in ACCUM and HOLD, with no state change.
REQ-027 prod_valid SHALL be ignored in IDLE and HOLD.
REQ-028 start in the same cycle as the HOLD acc_ready handshake SHALL be ignored; the next start is honoured only once in IDLE.
REQ-029 len == 2^LEN_W-1 SHALL be supported with no counter wrap; cnt never decrements below 1 while in ACCUM.

Reset
REQ-030 While rst=1, the block SHALL force state=IDLE, acc=0, cnt=0, ovf=0, acc_valid=0 and busy=0, regardless of clk.
REQ-031 Reset asserted mid-ACCUM or mid-HOLD SHALL discard the partial result, with no acc_valid pulse.
REQ-032 After rst deasserts, the first start SHALL be honourable on the first rising edge.

Verification
REQ-033 start with len=4, bias=10; products 3, -5, 127, -16384, each on a prod_valid cycle -> acc_valid one cycle after the 4th product, acc_out=-16249, ovf=0.
REQ-034 start with len=0, bias=-7 -> acc_valid on the next cycle, acc_out=-7, busy=1 until the handshake.
REQ-035 bias=2^31-100, len=2, products 16129, 16129 -> acc_out=2147483647, ovf=1; the next start clears ovf.
REQ-036 len=3 with prod_valid gaps of 0-5 cycles, and acc_ready held low 10 cycles in HOLD -> acc_out stable throughout, one result per handshake, start pulses during busy ignored.
REQ-037 rst pulse after 2 of 5 products -> outputs zero immediately; a new start with len=1, bias=0, product 9 -> acc_out=9.
REQ-038 Randomized sequences against a reference model of saturated sums -> every acc_out and ovf match.
